ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Configuration-chain loader that sits directly upstream of the switch-block and connection-block configuration chains. It accepts configuration words over a valid/ready interface and serializes them onto `ccff_head`, one bit per shift cycle, until exactly CHAIN_LEN bits have been shifted. An optional verify pass recirculates `ccff_tail` into `ccff_head` for CHAIN_LEN cycles and compares the ones-count read back against the ones-count loaded, which leaves the chain contents intact.

## Interface
- CHAIN_LEN, 24: total configuration bits in the downstream chain (must be ≥1)
- WORD_W, 8: bits per input word
- CNT_W, $clog2(CHAIN_LEN+1): width of bit and ones counters
- prog_clk  in  1  programming clock; one clock domain
- pReset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse that begins a load; ignored unless IDLE
- verify  in  1  sampled with `start`; 1 = run a verify pass after the load
- word_data  in  WORD_W  configuration word; bit 0 is shifted first
- word_valid  in  1  `word_data` is valid
- word_ready  out  1  loader accepts a word this cycle
- ccff_head  out  1  serial data to the chain head
- chain_shift_en  out  1  chain flops advance at the next prog_clk edge (drives the external clock gate)
- ccff_tail  in  1  serial data from the chain tail
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  verify mismatch; valid while `done`=1, then held until the next `start`
- bit_count  out  CNT_W  bits shifted in the current pass

## Operation
- **States:** IDLE, WAIT_WORD, SHIFT, VERIFY, DONE.
- **IDLE, on `start`:** go to WAIT_WORD; latch `verify`; clear bit_count, ones_load, ones_rb and error.
- **WAIT_WORD:**
  - `word_ready`=1.
  - On `word_valid`: load `word_data` into the shift register, set the in-word index to 0, and go to SHIFT.
- **SHIFT:**
  - `chain_shift_en`=1 and `ccff_head`=sreg[0].
  - Each cycle: shift sreg right, increment bit_count, and add `ccff_head` to ones_load.
  - After shifting the bit that makes bit_count == CHAIN_LEN: go to VERIFY if verify is latched, else DONE.
  - Otherwise, after WORD_W bits go back to WAIT_WORD.
- **Partial final word:** the unused upper bits of the last word are discarded.
- **VERIFY:**
  - Clear bit_count on entry.
  - `chain_shift_en`=1 and `ccff_head`=`ccff_tail` (combinational recirculation).
  - Each cycle: add `ccff_tail` to ones_rb and increment bit_count.
  - After CHAIN_LEN cycles go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
  - error = (ones_rb ≠ ones_load) when verify is latched, else 0.
- **Bit order:** the first bit shifted ends in the flop nearest `ccff_tail`.

## Timing
- **Reset values:** word_ready 0, ccff_head 0, chain_shift_en 0, busy 0, done 0, error 0, bit_count 0; state IDLE; all counters 0.
- **Reset mid-operation:** state returns to IDLE on the next edge. Chain contents are undefined afterwards; a fresh load is required.
- **Start latency:** `start` in cycle 0 → `word_ready` in cycle 1.
- **Per-word cost:** one accept cycle plus min(WORD_W, remaining) shift cycles. With `word_valid` held high, no other bubbles occur.
- **Load length:** total load cycles = ceil(CHAIN_LEN/WORD_W) + CHAIN_LEN. With verify, add CHAIN_LEN. `done` follows in the next cycle.
- **Outside SHIFT/VERIFY:** `chain_shift_en` is low and `ccff_head` holds 0.
- **Words while not WAIT_WORD:** a word presented outside WAIT_WORD is not consumed (`word_ready`=0).
- **Ignored starts:** `start` while busy has no effect.
- **Handshake rules:** `word_ready` does not depend combinationally on `word_valid`. A transfer occurs only when valid && ready.

## Structure
- Package `ccff_loader_pkg`:
  - state enum `ccff_ld_state_t`
  - localparam for words-per-chain = ceil(CHAIN_LEN/WORD_W)
- One sub-module: `ccff_word_serializer`. It holds the WORD_W shift register and the in-word index, and outputs `bit_out` and `word_last`.
- The FSM and counters live in the top module.

## Test plan
- **Full load, no verify:** CHAIN_LEN=24, words 0xA5, 0x3C, 0x0F back-to-back → 27 busy cycles before `done`.
  - `ccff_head` shows 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1,0,0,0,0 on `chain_shift_en` cycles.
  - ones_load = 12; `error` = 0.
- **Partial final word:** CHAIN_LEN=20, words 0xFF ×3 → exactly 20 shift cycles.
  - The third word contributes 4 bits; bit_count ends at 20.
- **Verify pass:** behavioral 24-bit chain model, load as in the first test with `verify`=1 → 24 recirculation cycles.
  - `error`=0, and the chain model is bit-identical to its pre-verify contents.
- **Verify with fault:** force one chain bit to flip between load and verify → `error`=1 at `done`, and it stays 1 until the next `start`.
- **Stall:** `word_valid` low for 5 cycles between words 1 and 2 → `chain_shift_en`=0 and `bit_count` frozen at 8 through the stall.
  - Shifting resumes one cycle after the transfer.
- **Reset mid-load:** `pReset` after bit_count = 10 → the next cycle shows busy=0, bit_count=0, chain_shift_en=0.
  - A subsequent `start` completes a normal 24-bit load.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
//   Shared types and sizing helpers for the configuration-chain loader.
//   - ccff_ld_state_t : loader FSM state encoding
//   - words_per_chain : number of input words needed to fill a chain
//   - WORDS_PER_CHAIN : words per chain for the default 24-bit / 8-bit build
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_WAIT_WORD,
    LD_SHIFT,
    LD_VERIFY,
    LD_DONE
  } ccff_ld_state_t;

  localparam int unsigned CHAIN_LEN_DEFAULT = 24;
  localparam int unsigned WORD_W_DEFAULT    = 8;

  function automatic int unsigned words_per_chain(input int unsigned chain_len,
                                                  input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  localparam int unsigned WORDS_PER_CHAIN =
    words_per_chain(CHAIN_LEN_DEFAULT, WORD_W_DEFAULT);

endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer
//   Holds one configuration word and presents it LSB first.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     load          : capture word_data, restart the in-word index at 0
//     shift         : advance to the next bit of the word
//     word_data     : word to serialize
//     bit_out       : current bit (sreg[0])
//     word_last     : current bit is the last bit of the word
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] word_data,
  output logic              bit_out,
  output logic              word_last
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] sreg;
  logic [IDX_W-1:0]  idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      idx  <= '0;
    end else if (load) begin
      sreg <= word_data;
      idx  <= '0;
    end else if (shift) begin
      sreg <= sreg >> 1;
      idx  <= idx + 1'b1;
    end
  end

  assign bit_out   = sreg[0];
  assign word_last = (idx == LAST_IDX);

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Serializes configuration words onto a CHAIN_LEN-bit configuration chain,
//   optionally followed by a recirculating verify pass that compares the
//   ones-count read back from the tail with the ones-count loaded.
//   Ports:
//     prog_clk, pReset         : clock, synchronous active-high reset
//     start, verify            : begin a load (IDLE only); request verify pass
//     word_data/valid/ready    : word input handshake, bit 0 shifted first
//     ccff_head, ccff_tail     : serial data to chain head / from chain tail
//     chain_shift_en           : chain advances on the next prog_clk edge
//     busy, done, error        : status; error held until the next start
//     bit_count                : bits shifted in the current pass
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 24,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              chain_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  ccff_ld_state_t   state, state_nxt;
  logic             verify_q;
  logic             error_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] ones_load;
  logic [CNT_W-1:0] ones_rb;

  logic ser_load, ser_shift, ser_bit, ser_last;
  logic last_bit;

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk       (prog_clk),
    .rst       (pReset),
    .load      (ser_load),
    .shift     (ser_shift),
    .word_data (word_data),
    .bit_out   (ser_bit),
    .word_last (ser_last)
  );

  // Chain length, not word boundary, ends the load: this truncates a partial
  // final word without needing a per-word bit budget.
  assign last_bit = (bit_cnt_q == LAST_CNT);

  always_comb begin
    state_nxt      = state;
    word_ready     = 1'b0;
    chain_shift_en = 1'b0;
    ccff_head      = 1'b0;
    ser_load       = 1'b0;
    ser_shift      = 1'b0;
    case (state)
      LD_IDLE: begin
        if (start) state_nxt = LD_WAIT_WORD;
      end
      LD_WAIT_WORD: begin
        word_ready = 1'b1;
        if (word_valid) begin
          ser_load  = 1'b1;
          state_nxt = LD_SHIFT;
        end
      end
      LD_SHIFT: begin
        chain_shift_en = 1'b1;
        ccff_head      = ser_bit;
        ser_shift      = 1'b1;
        if (last_bit)      state_nxt = verify_q ? LD_VERIFY : LD_DONE;
        else if (ser_last) state_nxt = LD_WAIT_WORD;
      end
      LD_VERIFY: begin
        chain_shift_en = 1'b1;
        ccff_head      = ccff_tail;
        if (last_bit) state_nxt = LD_DONE;
      end
      LD_DONE: begin
        state_nxt = LD_IDLE;
      end
      default: state_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state     <= LD_IDLE;
      verify_q  <= 1'b0;
      error_q   <= 1'b0;
      bit_cnt_q <= '0;
      ones_load <= '0;
      ones_rb   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        LD_IDLE: begin
          if (start) begin
            verify_q  <= verify;
            error_q   <= 1'b0;
            bit_cnt_q <= '0;
            ones_load <= '0;
            ones_rb   <= '0;
          end
        end
        LD_SHIFT: begin
          ones_load <= ones_load + CNT_W'(ser_bit);
          // bit_count restarts for the verify pass; without verify it keeps
          // the final load count.
          if (last_bit && verify_q) bit_cnt_q <= '0;
          else                      bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        LD_VERIFY: begin
          ones_rb   <= ones_rb + CNT_W'(ccff_tail);
          bit_cnt_q <= bit_cnt_q + 1'b1;
          // Include this cycle's tail bit so error is ready in DONE.
          if (last_bit) error_q <= ((ones_rb + CNT_W'(ccff_tail)) != ones_load);
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != LD_IDLE);
  assign done      = (state == LD_DONE);
  assign error     = error_q;
  assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader
//   Directed bench for ccff_chain_loader with a behavioral 24-bit chain model
//   (chain[23] nearest the head, chain[0] drives ccff_tail). A second instance
//   built with CHAIN_LEN=20 covers the partial final word.
module tb_ccff_chain_loader;

  logic       prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic       pReset, start, verify, word_valid, ccff_tail;
  logic [7:0] word_data;
  logic       word_ready, ccff_head, chain_shift_en, busy, done, error;
  logic [4:0] bit_count;

  logic       start20, valid20;
  logic       ready20, head20, sen20, busy20, done20, err20;
  logic [4:0] bc20;

  logic [23:0] chain;
  assign ccff_tail = chain[0];

  int n_checks = 0;
  int n_pass   = 0;

  ccff_chain_loader #(.CHAIN_LEN(24), .WORD_W(8)) dut (
    .prog_clk       (prog_clk),
    .pReset         (pReset),
    .start          (start),
    .verify         (verify),
    .word_data      (word_data),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .ccff_head      (ccff_head),
    .chain_shift_en (chain_shift_en),
    .ccff_tail      (ccff_tail),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .bit_count      (bit_count)
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut20 (
    .prog_clk       (prog_clk),
    .pReset         (pReset),
    .start          (start20),
    .verify         (1'b0),
    .word_data      (8'hFF),
    .word_valid     (valid20),
    .word_ready     (ready20),
    .ccff_head      (head20),
    .chain_shift_en (sen20),
    .ccff_tail      (1'b0),
    .busy           (busy20),
    .done           (done20),
    .error          (err20),
    .bit_count      (bc20)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: the chain model shifts with the head/enable seen before the
  // edge, updated just after the edge so the DUT samples the old tail.
  task automatic tick();
    logic h, s;
    h = ccff_head;
    s = chain_shift_en;
    @(posedge prog_clk);
    #1;
    if (s) chain = {h, chain[23:1]};
    #1;
  endtask

  // Runs one load of three words (words[7:0] first). Returns in the DONE
  // cycle, or right after a mid-load reset when rst_at >= 0.
  task automatic run_load(input logic [23:0] words, input logic vfy,
                          input int stall, input int flip_idx, input int rst_at,
                          output int busy_cyc, output logic [23:0] head_bits,
                          output int shifts, output logic err_done,
                          output logic [23:0] pre_verify, output logic timeout);
    int   widx;
    int   stall_left;
    bit   flipped, captured, expect_shift;
    widx = 0; stall_left = stall; flipped = 0; captured = 0; expect_shift = 0;
    busy_cyc = 0; head_bits = '0; shifts = 0; err_done = 1'b0; timeout = 1'b1;
    pre_verify = chain;
    start = 1'b1; verify = vfy;
    tick();
    start = 1'b0; verify = 1'b0;
    check("start_latency_ready", word_ready, 1);
    check("error_cleared_on_start", error, 0);
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        err_done = error; timeout = 1'b0;
        break;
      end
      if (rst_at >= 0 && bit_count == rst_at[4:0] && chain_shift_en) begin
        pReset = 1'b1; word_valid = 1'b0;
        tick();
        pReset = 1'b0; timeout = 1'b0;
        break;
      end
      if (expect_shift) begin
        check("resume_shift_en", chain_shift_en, 1);
        expect_shift = 0;
      end
      if (widx == 1 && stall_left > 0 && word_ready) begin
        word_valid = 1'b0;
        check("stall_shift_en", chain_shift_en, 0);
        check("stall_bit_count", bit_count, 8);
        stall_left--;
      end else begin
        word_valid = (widx < 3);
        word_data  = (widx < 3) ? words[8*widx +: 8] : 8'h00;
      end
      if (word_ready && word_valid) begin
        widx++;
        if (stall > 0 && widx == 2) expect_shift = 1;
      end
      if (shifts == 24 && !captured) begin
        pre_verify = chain; captured = 1;
        if (flip_idx >= 0 && !flipped) begin
          chain[flip_idx] = ~chain[flip_idx];
          flipped = 1;
          #1;
        end
      end
      if (busy) busy_cyc++;
      if (chain_shift_en) begin
        if (shifts < 24) head_bits[shifts] = ccff_head;
        shifts++;
      end
      tick();
    end
    word_valid = 1'b0;
  endtask

  initial begin
    int          bc, sh, n3, nw;
    logic [23:0] hb, pv;
    logic        ed, to;

    pReset = 1'b1; start = 1'b0; verify = 1'b0; word_valid = 1'b0;
    word_data = 8'h00; start20 = 1'b0; valid20 = 1'b0; chain = '0;
    tick(); tick();
    check("rst_word_ready", word_ready, 0);
    check("rst_ccff_head", ccff_head, 0);
    check("rst_shift_en", chain_shift_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_bit_count", bit_count, 0);
    pReset = 1'b0;
    tick();

    // Full load, no verify
    run_load(24'h0F3CA5, 1'b0, 0, -1, -1, bc, hb, sh, ed, pv, to);
    check("full_timeout", to, 0);
    check("full_busy_cycles", bc, 27);
    check("full_shifts", sh, 24);
    check("full_head_seq", hb, 24'h0F3CA5);
    check("full_ones_seen", $countones(hb), 12);
    check("full_ones_load", dut.ones_load, 12);
    check("full_error", ed, 0);
    check("full_bit_count", bit_count, 24);
    check("full_chain", chain, 24'h0F3CA5);
    tick();
    check("full_done_pulse", done, 0);
    check("full_idle", busy, 0);
    check("idle_head_zero", ccff_head, 0);

    // Verify pass, clean chain
    run_load(24'h0F3CA5, 1'b1, 0, -1, -1, bc, hb, sh, ed, pv, to);
    check("vfy_timeout", to, 0);
    check("vfy_busy_cycles", bc, 51);
    check("vfy_shifts", sh, 48);
    check("vfy_head_seq", hb, 24'h0F3CA5);
    check("vfy_pre_chain", pv, 24'h0F3CA5);
    check("vfy_post_chain", chain, 24'h0F3CA5);
    check("vfy_ones_rb", dut.ones_rb, 12);
    check("vfy_bit_count", bit_count, 24);
    check("vfy_error", ed, 0);
    tick();

    // Verify pass with one flipped chain bit
    run_load(24'h0F3CA5, 1'b1, 0, 5, -1, bc, hb, sh, ed, pv, to);
    check("fault_timeout", to, 0);
    check("fault_error_at_done", ed, 1);
    tick();
    check("fault_error_held_idle", error, 1);
    tick(); tick(); tick();
    check("fault_error_held_late", error, 1);

    // Stall between words 1 and 2 (also confirms error cleared by start)
    run_load(24'h0F3CA5, 1'b0, 5, -1, -1, bc, hb, sh, ed, pv, to);
    check("stall_timeout", to, 0);
    check("stall_busy_cycles", bc, 32);
    check("stall_head_seq", hb, 24'h0F3CA5);
    tick();

    // Reset in the middle of a load, then a clean reload
    run_load(24'h0F3CA5, 1'b0, 0, -1, 10, bc, hb, sh, ed, pv, to);
    check("midrst_reached", to, 0);
    check("midrst_busy", busy, 0);
    check("midrst_bit_count", bit_count, 0);
    check("midrst_shift_en", chain_shift_en, 0);
    check("midrst_ready", word_ready, 0);
    tick();
    run_load(24'h0F3CA5, 1'b0, 0, -1, -1, bc, hb, sh, ed, pv, to);
    check("reload_timeout", to, 0);
    check("reload_busy_cycles", bc, 27);
    check("reload_chain", chain, 24'h0F3CA5);
    tick();

    // Partial final word on the 20-bit instance
    start20 = 1'b1;
    tick();
    start20 = 1'b0;
    sh = 0; n3 = 0; nw = 0; to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (done20) begin
        to = 1'b0;
        break;
      end
      valid20 = 1'b1;
      if (ready20) nw++;
      if (sen20) begin
        sh++;
        if (nw == 3) n3++;
      end
      tick();
    end
    valid20 = 1'b0;
    check("part_timeout", to, 0);
    check("part_shifts", sh, 20);
    check("part_third_word_bits", n3, 4);
    check("part_bit_count", bc20, 20);
    check("part_error", err20, 0);
    tick();
    check("part_idle", busy20, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
